// File: rtl/apu_pkg.sv
// Shared constants for the APU channel blocks: default field widths, the
// envelope ceiling, and the indices of the per-channel frame ticks.
package apu_pkg;

  localparam int VOL_W_DEF = 4;
  localparam int LEN_W_DEF = 8;

  localparam int DECAY_MAX = 15;

  localparam int TICK_ENV   = 0;
  localparam int TICK_LEN   = 1;
  localparam int TICK_COUNT = 2;

endpackage

// File: rtl/envelope_length_if.sv
// Channel-control bundle between the frame/register logic (master) and the
// envelope + length stage (slave).
interface envelope_length_if
  import apu_pkg::*;
#(
  parameter int VOL_W = VOL_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic             iSquare;
  logic             iEnv_clk;
  logic             iLen_clk;
  logic             iEnable;
  logic             iLoad;
  logic [LEN_W-1:0] iLen_value;
  logic             iConst_vol;
  logic [VOL_W-1:0] iVolume;
  logic             iLoop;
  logic [VOL_W-1:0] oSample;
  logic             oActive;

  modport master (
    output iSquare, iEnv_clk, iLen_clk, iEnable, iLoad, iLen_value,
           iConst_vol, iVolume, iLoop,
    input  oSample, oActive
  );

  modport slave (
    input  iSquare, iEnv_clk, iLen_clk, iEnable, iLoad, iLen_value,
           iConst_vol, iVolume, iLoop,
    output oSample, oActive
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for a slow frame-clock level: two sync registers,
// tick = cur & ~old, so the consumer acts 2 clk after the level rises.
module edge_detect (
  input  logic clk,
  input  logic iReset,
  input  logic level,
  output logic tick
);

  logic cur;
  logic old;
  logic primed;

  // On the first clock after reset both registers take the live level, so a
  // level already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      cur    <= 1'b0;
      old    <= 1'b0;
      primed <= 1'b0;
    end else begin
      cur    <= level;
      old    <= primed ? cur : level;
      primed <= 1'b1;
    end
  end

  assign tick = cur & ~old;

endmodule

// File: rtl/envelope_length.sv
// Envelope generator and length counter for one pulse-style APU channel;
// gates the incoming square wave into a registered amplitude.
module envelope_length
  import apu_pkg::*;
#(
  parameter int VOL_W = VOL_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic              clk,
  input logic              iReset,
  envelope_length_if.slave bus
);

  localparam logic [VOL_W-1:0] DECAY_TOP = VOL_W'(DECAY_MAX);

  logic [TICK_COUNT-1:0] ticks;
  logic                  env_tick;
  logic                  len_tick;
  logic                  start;
  logic [VOL_W-1:0]      decay;
  logic [VOL_W-1:0]      divider;
  logic [LEN_W-1:0]      length;

  edge_detect env_edge (
    .clk   (clk),
    .iReset(iReset),
    .level (bus.iEnv_clk),
    .tick  (ticks[TICK_ENV])
  );

  edge_detect len_edge (
    .clk   (clk),
    .iReset(iReset),
    .level (bus.iLen_clk),
    .tick  (ticks[TICK_LEN])
  );

  assign env_tick = ticks[TICK_ENV];
  assign len_tick = ticks[TICK_LEN];

  // A load landing on an env tick restarts at once instead of waiting a tick.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      start   <= 1'b0;
      decay   <= '0;
      divider <= '0;
    end else if (env_tick) begin
      if (start || bus.iLoad) begin
        start   <= 1'b0;
        decay   <= DECAY_TOP;
        divider <= bus.iVolume;
      end else if (divider == '0) begin
        divider <= bus.iVolume;
        if (decay != '0) begin
          decay <= decay - VOL_W'(1);
        end else if (bus.iLoop) begin
          decay <= DECAY_TOP;
        end
      end else begin
        divider <= divider - VOL_W'(1);
      end
    end else if (bus.iLoad) begin
      start <= 1'b1;
    end
  end

  // Disable beats load, load beats a coincident decrement; iLoop halts counting.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      length <= '0;
    end else if (!bus.iEnable) begin
      length <= '0;
    end else if (bus.iLoad) begin
      length <= bus.iLen_value;
    end else if (len_tick && (length != '0) && !bus.iLoop) begin
      length <= length - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      bus.oSample <= '0;
      bus.oActive <= 1'b0;
    end else begin
      bus.oSample <= ((length != '0) && bus.iSquare)
                     ? (bus.iConst_vol ? bus.iVolume : decay)
                     : '0;
      bus.oActive <= (length != '0);
    end
  end

endmodule

// File: tb/tb_envelope_length.sv
// Bench for envelope_length: directed scenarios with literal expectations,
// then random traffic, all shadowed by a cycle-level reference model.
module tb_envelope_length;
  import apu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  envelope_length_if bus ();

  envelope_length dut (
    .clk   (clk),
    .iReset(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit model_on = 1'b0;
  int m_k, m_e1, m_e2, m_l1, m_l2;
  int m_start, m_decay, m_div, m_len;
  int m_sample, m_active;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_e1 = 0; m_e2 = 0; m_l1 = 0; m_l2 = 0;
    m_start = 0; m_decay = 0; m_div = 0; m_len = 0;
    m_sample = 0; m_active = 0;
  endtask

  // One clock of the channel, written from the behavioural rules: an edge is
  // a 0->1 of the level seen two clocks back, never in the first two clocks.
  task automatic model_step();
    int et, lt;
    int vol, lval;
    vol  = int'(bus.iVolume);
    lval = int'(bus.iLen_value);
    m_k++;
    et = (m_k >= 3 && m_e1 == 1 && m_e2 == 0) ? 1 : 0;
    lt = (m_k >= 3 && m_l1 == 1 && m_l2 == 0) ? 1 : 0;
    m_e2 = m_e1; m_e1 = int'(bus.iEnv_clk);
    m_l2 = m_l1; m_l1 = int'(bus.iLen_clk);

    m_sample = (m_len != 0 && bus.iSquare) ? (bus.iConst_vol ? vol : m_decay) : 0;
    m_active = (m_len != 0) ? 1 : 0;

    if (et == 1) begin
      if (m_start == 1 || bus.iLoad) begin
        m_start = 0; m_decay = 15; m_div = vol;
      end else if (m_div == 0) begin
        m_div = vol;
        if (m_decay > 0) m_decay = m_decay - 1;
        else if (bus.iLoop) m_decay = 15;
      end else begin
        m_div = m_div - 1;
      end
    end else if (bus.iLoad) begin
      m_start = 1;
    end

    if (!bus.iEnable) m_len = 0;
    else if (bus.iLoad) m_len = lval;
    else if (lt == 1 && m_len > 0 && !bus.iLoop) m_len = m_len - 1;
  endtask

  initial begin : compare_proc
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
        model_on = 1'b1;
      end else if (model_on) begin
        model_step();
      end
      #1;
      if (model_on) begin
        check_output("model_sample", 32'(bus.oSample), 32'(m_sample));
        check_output("model_active", 32'(bus.oActive), 32'(m_active));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic env_edge();
    bus.iEnv_clk = 1'b1; cycles(2);
    bus.iEnv_clk = 1'b0; cycles(2);
  endtask

  task automatic len_edge();
    bus.iLen_clk = 1'b1; cycles(2);
    bus.iLen_clk = 1'b0; cycles(2);
  endtask

  task automatic load_pulse();
    bus.iLoad = 1'b1; cycles(1);
    bus.iLoad = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cycles(2);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.iSquare = 1'b0; bus.iEnv_clk = 1'b0; bus.iLen_clk = 1'b0;
    bus.iEnable = 1'b1; bus.iLoad = 1'b0; bus.iLen_value = '0;
    bus.iConst_vol = 1'b0; bus.iVolume = '0; bus.iLoop = 1'b0;
  endtask

  // Random traffic: slow frame clocks, sparse loads and short resets.
  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) bus.iEnv_clk = ~bus.iEnv_clk;
      if ($urandom_range(0, 5) == 0) bus.iLen_clk = ~bus.iLen_clk;
      bus.iLoad      = ($urandom_range(0, 24) == 0);
      bus.iLen_value = 8'($urandom_range(0, 12));
      bus.iEnable    = ($urandom_range(0, 63) != 0);
      bus.iSquare    = 1'($urandom);
      if ($urandom_range(0, 31) == 0) bus.iConst_vol = ~bus.iConst_vol;
      if ($urandom_range(0, 31) == 0) bus.iLoop = ~bus.iLoop;
      if ($urandom_range(0, 15) == 0) bus.iVolume = 4'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stimulus_proc
    rst = 1'b1;
    idle_inputs();
    cycles(3);
    check_output("reset_sample", 32'(bus.oSample), 32'd0);
    check_output("reset_active", 32'(bus.oActive), 32'd0);
    rst = 1'b0;
    cycles(2);

    // constant volume follows the square wave
    bus.iConst_vol = 1'b1; bus.iVolume = 4'd9; bus.iLen_value = 8'd5;
    load_pulse();
    bus.iSquare = 1'b1; cycles(1);
    check_output("const_hi", 32'(bus.oSample), 32'd9);
    check_output("const_active", 32'(bus.oActive), 32'd1);
    bus.iSquare = 1'b0; cycles(1);
    check_output("const_lo", 32'(bus.oSample), 32'd0);
    bus.iSquare = 1'b1; cycles(1);
    check_output("const_hi2", 32'(bus.oSample), 32'd9);

    // decay without loop: one step every 2 env edges, then parks at 0
    do_reset();
    bus.iConst_vol = 1'b0; bus.iVolume = 4'd1; bus.iLoop = 1'b0;
    bus.iSquare = 1'b1; bus.iLen_value = 8'd200;
    load_pulse();
    env_edge();
    check_output("decay_first", 32'(bus.oSample), 32'd15);
    repeat (29) env_edge();
    check_output("decay_e30", 32'(bus.oSample), 32'd1);
    repeat (2) env_edge();
    check_output("decay_e32", 32'(bus.oSample), 32'd0);
    repeat (2) env_edge();
    check_output("decay_hold", 32'(bus.oSample), 32'd0);
    check_output("decay_active", 32'(bus.oActive), 32'd1);

    // decay with loop wraps back to 15
    do_reset();
    bus.iLoop = 1'b1;
    load_pulse();
    repeat (32) env_edge();
    check_output("loop_e32", 32'(bus.oSample), 32'd0);
    env_edge();
    check_output("loop_wrap", 32'(bus.oSample), 32'd15);

    // length expiry after 3 half-frame edges
    do_reset();
    bus.iLoop = 1'b0; bus.iConst_vol = 1'b1; bus.iVolume = 4'd9;
    bus.iLen_value = 8'd3;
    load_pulse();
    repeat (2) len_edge();
    check_output("len_after2", 32'(bus.oActive), 32'd1);
    bus.iLen_clk = 1'b1; cycles(2);
    check_output("len_update_edge", 32'(bus.oActive), 32'd1);
    cycles(1);
    check_output("len_expired", 32'(bus.oActive), 32'd0);
    check_output("len_sample0", 32'(bus.oSample), 32'd0);
    bus.iLen_clk = 1'b0; cycles(2);

    // load coinciding with a len tick wins over the decrement
    do_reset();
    bus.iLen_value = 8'd3;
    load_pulse();
    bus.iLen_clk = 1'b1; cycles(1);
    bus.iLoad = 1'b1; bus.iLen_value = 8'd7; cycles(1);
    bus.iLoad = 1'b0; bus.iLen_clk = 1'b0; cycles(2);
    repeat (6) len_edge();
    check_output("coinc_len6", 32'(bus.oActive), 32'd1);
    len_edge();
    check_output("coinc_len7", 32'(bus.oActive), 32'd0);

    // disabling the channel clears length; oActive follows one clock later
    load_pulse();
    cycles(1);
    bus.iEnable = 1'b0; cycles(1);
    check_output("disable_1clk", 32'(bus.oActive), 32'd1);
    cycles(1);
    check_output("disable_2clk", 32'(bus.oActive), 32'd0);
    bus.iEnable = 1'b1;

    // reset mid-decay with the env clock held high
    do_reset();
    bus.iConst_vol = 1'b0; bus.iVolume = 4'd1; bus.iSquare = 1'b1;
    bus.iLen_value = 8'd200;
    load_pulse();
    repeat (4) env_edge();
    bus.iEnv_clk = 1'b1; cycles(3);
    rst = 1'b1; #1;
    check_output("reset_imm_sample", 32'(bus.oSample), 32'd0);
    check_output("reset_imm_active", 32'(bus.oActive), 32'd0);
    cycles(2);
    rst = 1'b0; bus.iLoad = 1'b1; cycles(1);
    bus.iLoad = 1'b0; cycles(6);
    check_output("reset_no_tick", 32'(bus.oSample), 32'd0);
    check_output("reset_reload", 32'(bus.oActive), 32'd1);
    bus.iEnv_clk = 1'b0; cycles(2);

    apply_stimulus(4000);
    cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/envelope_length.md
ENVELOPE_LENGTH -- requirements
Module: envelope_length

Interface
REQ-001 SHALL have parameter VOL_W, default 4, meaning the width of the volume and decay fields.
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the length counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iReset, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port iSquare, input, 1, square wave from the frequency stage (its oData).
REQ-006 SHALL have port iEnv_clk, input, 1, quarter-frame clock level; its rising edge is detected internally.
REQ-007 SHALL have port iLen_clk, input, 1, half-frame clock level; its rising edge is detected internally.
REQ-008 SHALL have port iEnable, input, 1, channel enable; low forces the length counter to 0.
REQ-009 SHALL have port iLoad, input, 1, one-cycle pulse that loads the length counter and restarts the envelope.
REQ-010 SHALL have port iLen_value, input, LEN_W, the length reload value.
REQ-011 SHALL have port iConst_vol, input, 1, select: 1 = constant volume, 0 = envelope decay.
REQ-012 SHALL have port iVolume, input, VOL_W, the constant volume or the envelope divider period.
REQ-013 SHALL have port iLoop, input, 1, envelope loop enable and length-counter halt.
REQ-014 SHALL have port oSample, output, VOL_W, registered channel amplitude.
REQ-015 SHALL have port oActive, output, 1, registered flag, high while the length counter is nonzero.

Function
REQ-016 SHALL detect rising edges of iEnv_clk and iLen_clk with two sync registers per input (cur, old); a tick is cur and not old; the state update is visible 2 clk after the input rises.
REQ-017 SHALL set the start flag on iLoad.
REQ-018 SHALL, on an env tick with start set: clear start, set decay=15, set divider=iVolume.
REQ-019 SHALL, on an env tick with start clear and divider==0: set divider=iVolume; then if decay>0, decrement decay; else if iLoop, set decay=15; else hold decay at 0.
REQ-020 SHALL, on an env tick with start clear and divider!=0, decrement divider.
REQ-021 SHALL, when iLoad and an env tick occur in the same cycle, apply the restart immediately (decay=15, divider=iVolume) and leave start clear.
REQ-022 SHALL, on iLoad with iEnable=1, load length=iLen_value; iLoad with iEnable=0 SHALL NOT load length.
REQ-023 SHALL, on a len tick with length!=0 and iLoop=0, decrement length; no wrap below 0.
REQ-024 SHALL, when iLoad coincides with a len tick, let the load win (no decrement that cycle).
REQ-025 SHALL clear length on the clk after iEnable is sampled low, overriding load and tick.
REQ-026 SHALL register oSample = (length!=0 and iSquare) ? (iConst_vol ? iVolume : decay) : 0, 1 clk after its inputs.
REQ-027 SHALL register oActive = (length!=0), 1 clk after its inputs.
REQ-028 SHALL use unsigned arithmetic only; decay, divider and length never wrap.

Reset
REQ-029 SHALL, while iReset is high, asynchronously clear oSample, oActive, length, decay, divider, start and all edge registers to 0.
REQ-030 SHALL, on iReset mid-envelope or mid-count, abandon the operation; iEnv_clk or iLen_clk held high through deassertion SHALL NOT produce a tick.

Structure
REQ-031 SHALL place VOL_W and LEN_W defaults, DECAY_MAX=15 and the tick-type constants in shared package apu_pkg.
REQ-032 SHALL instantiate sub-module edge_detect (clk, iReset, level in, tick out) twice: once for envelope, once for length.

Verification
REQ-033 SHALL test constant volume: iConst_vol=1, iVolume=9, iLoad with iLen_value=5, iSquare toggling -> oSample alternates 9/0 and oActive=1.
REQ-034 SHALL test decay: iConst_vol=0, iVolume=1, iLoad, then 32 env edges -> decay steps 15,14,... once every 2 edges, reaching 0 and holding 0 (iLoop=0).
REQ-035 SHALL test loop: same as REQ-034 with iLoop=1 -> decay wraps from 0 to 15 on the next divider expiry.
REQ-036 SHALL test length expiry: iLen_value=3, iLoop=0, 3 len edges -> oActive falls 1 clk after the third update and oSample=0.
REQ-037 SHALL test coincidence: iLoad on the same cycle as a len tick -> length=iLen_value (not decremented); iEnable dropped mid-count -> oActive=0 2 clk later.
REQ-038 SHALL test reset: iReset pulsed mid-decay with iEnv_clk held high -> all outputs 0 immediately and no tick after release.
